// File: rtl/mem_stage_sa_cache.sv
// Memory stage: N-way set-associative read cache with LRU replacement in front of
// a write-through, no-write-allocate SRAM path, with pipeline stall and load statistics.
module mem_stage_sa_cache #(
    parameter int SETS         = 64,
    parameter int WAYS         = 2,
    parameter int SRAM_WAIT    = 5,
    parameter int SRAM_ADDR_W  = 17,
    parameter int BASE_ADDR    = 1024,
    parameter int WRITE_UPDATE = 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   MEMread,
    input  logic                   MEMwrite,
    input  logic [31:0]            address,
    input  logic [31:0]            data,
    output logic [31:0]            MEM_result,
    output logic                   mem_ready,
    output logic [SRAM_ADDR_W-1:0] SRAM_ADDR,
    output logic                   SRAM_WE_N,
    output logic [1:0]             SRAM_BE_N,
    output logic [63:0]            SRAM_WDATA,
    input  logic [63:0]            SRAM_RDATA,
    output logic [31:0]            hit_count,
    output logic [31:0]            miss_count
);
    localparam int IDX_W = $clog2(SETS);
    localparam int TAG_W = SRAM_ADDR_W - IDX_W;
    localparam int CNT_W = $clog2(SRAM_WAIT + 1);

    typedef enum logic {IDLE, ACCESS} state_t;
    state_t state, state_nxt;

    logic [CNT_W-1:0] cnt;
    logic             wsel_q, store_q;
    logic [31:0]      wdata_q;

    logic [WAYS-1:0][SETS-1:0] valid;
    logic [SETS-1:0]           lru;
    logic [TAG_W-1:0]          tag_mem  [WAYS][SETS];
    logic [63:0]               data_mem [WAYS][SETS];

    logic [31:0]            eff;
    logic [SRAM_ADDR_W-1:0] line_in, line_l;
    logic [IDX_W-1:0]       set_l;
    logic [TAG_W-1:0]       tag_l;
    logic                   wsel_l, hit, hit_way, victim, found, done;
    logic [63:0]            hit_line;
    logic                   unused_bits;

    assign eff         = address - 32'(BASE_ADDR);
    assign line_in     = eff[3 +: SRAM_ADDR_W];
    assign unused_bits = ^{eff[1:0], eff[31:3+SRAM_ADDR_W]};

    // While an access is in flight the lookup runs on the latched line, so the
    // requester's inputs are don't-care until completion.
    assign line_l   = (state == IDLE) ? line_in : SRAM_ADDR;
    assign set_l    = line_l[IDX_W-1:0];
    assign tag_l    = line_l[SRAM_ADDR_W-1:IDX_W];
    assign wsel_l   = (state == IDLE) ? eff[2] : wsel_q;
    assign done     = (state == ACCESS) && (cnt == CNT_W'(SRAM_WAIT));
    assign hit_line = data_mem[hit_way][set_l];
    assign SRAM_WDATA = {wdata_q, wdata_q};

    always_comb begin
        hit     = 1'b0;
        hit_way = 1'b0;
        found   = 1'b0;
        victim  = 1'b0;
        for (int w = 0; w < WAYS; w++) begin
            if (!hit && valid[w][set_l] && tag_mem[w][set_l] == tag_l) begin
                hit     = 1'b1;
                hit_way = 1'(w);
            end
            if (!found && !valid[w][set_l]) begin
                found  = 1'b1;
                victim = 1'(w);
            end
        end
        if (!found)
            victim = (WAYS == 2) ? lru[set_l] : 1'b0;
    end

    always_comb begin
        state_nxt  = state;
        mem_ready  = 1'b1;
        MEM_result = '0;
        SRAM_WE_N  = 1'b1;
        SRAM_BE_N  = 2'b11;
        case (state)
            IDLE: begin
                if (MEMwrite || (MEMread && !hit)) begin
                    state_nxt = ACCESS;
                    mem_ready = 1'b0;
                end else if (MEMread) begin
                    MEM_result = wsel_l ? hit_line[63:32] : hit_line[31:0];
                end
            end
            ACCESS: begin
                if (!done) begin
                    mem_ready = 1'b0;
                    if (store_q) begin
                        SRAM_WE_N         = 1'b0;
                        SRAM_BE_N[wsel_q] = 1'b0;
                    end
                end else begin
                    state_nxt = IDLE;
                    if (!store_q)
                        MEM_result = wsel_q ? SRAM_RDATA[63:32] : SRAM_RDATA[31:0];
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            cnt        <= '0;
            hit_count  <= '0;
            miss_count <= '0;
            SRAM_ADDR  <= '0;
            valid      <= '0;
            lru        <= '0;
            store_q    <= 1'b0;
            wsel_q     <= 1'b0;
            wdata_q    <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (state_nxt == ACCESS) begin
                        cnt       <= '0;
                        SRAM_ADDR <= line_in;
                        wsel_q    <= eff[2];
                        store_q   <= MEMwrite;
                        wdata_q   <= data;
                    end else if (MEMread) begin
                        hit_count <= hit_count + 32'd1;
                        if (WAYS == 2)
                            lru[set_l] <= ~hit_way;
                    end
                end
                ACCESS: begin
                    cnt <= cnt + 1'b1;
                    if (done) begin
                        if (!store_q) begin
                            miss_count           <= miss_count + 32'd1;
                            valid[victim][set_l] <= 1'b1;
                            if (WAYS == 2)
                                lru[set_l] <= ~victim;
                        end else if (hit && WRITE_UPDATE == 0) begin
                            valid[hit_way][set_l] <= 1'b0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Tag/data arrays carry no reset; the valid bits alone qualify them.
    always_ff @(posedge clk) begin
        if (!reset && done) begin
            if (!store_q) begin
                tag_mem[victim][set_l]  <= tag_l;
                data_mem[victim][set_l] <= SRAM_RDATA;
            end else if (hit && WRITE_UPDATE != 0) begin
                if (wsel_q)
                    data_mem[hit_way][set_l][63:32] <= wdata_q;
                else
                    data_mem[hit_way][set_l][31:0]  <= wdata_q;
            end
        end
    end
endmodule

// File: tb/tb_mem_stage_sa_cache.sv
// Directed bench for mem_stage_sa_cache: two instances share stimulus, one with
// store-hit update and one with store-hit invalidate.
module tb_mem_stage_sa_cache;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        MEMread = 1'b0, MEMwrite = 1'b0;
    logic [31:0] address = '0, data = '0;
    logic [63:0] sram_rdata = '0;

    logic [31:0] mem_result, hit_count, miss_count;
    logic        mem_ready, sram_we_n;
    logic [16:0] sram_addr;
    logic [1:0]  sram_be_n;
    logic [63:0] sram_wdata;

    logic [31:0] mem_result_b, hit_count_b, miss_count_b;
    logic        mem_ready_b, sram_we_n_b;
    logic [16:0] sram_addr_b;
    logic [1:0]  sram_be_n_b;
    logic [63:0] sram_wdata_b;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_stage_sa_cache #(.WRITE_UPDATE(1)) u_dut (
        .clk(clk), .reset(reset), .MEMread(MEMread), .MEMwrite(MEMwrite),
        .address(address), .data(data), .MEM_result(mem_result), .mem_ready(mem_ready),
        .SRAM_ADDR(sram_addr), .SRAM_WE_N(sram_we_n), .SRAM_BE_N(sram_be_n),
        .SRAM_WDATA(sram_wdata), .SRAM_RDATA(sram_rdata),
        .hit_count(hit_count), .miss_count(miss_count)
    );

    mem_stage_sa_cache #(.WRITE_UPDATE(0)) u_dut_inv (
        .clk(clk), .reset(reset), .MEMread(MEMread), .MEMwrite(MEMwrite),
        .address(address), .data(data), .MEM_result(mem_result_b), .mem_ready(mem_ready_b),
        .SRAM_ADDR(sram_addr_b), .SRAM_WE_N(sram_we_n_b), .SRAM_BE_N(sram_be_n_b),
        .SRAM_WDATA(sram_wdata_b), .SRAM_RDATA(sram_rdata),
        .hit_count(hit_count_b), .miss_count(miss_count_b)
    );

    task automatic do_reset();
        @(posedge clk); #1;
        reset = 1'b1; MEMread = 1'b0; MEMwrite = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    // Called at posedge+1; returns at posedge+1 after the completing edge.
    task automatic do_load(input logic [31:0] a, input logic [63:0] rd, output int stalls,
                           output logic [31:0] res, output logic [16:0] seen, output logic ok);
        sram_rdata = rd; address = a; MEMread = 1'b1; MEMwrite = 1'b0;
        stalls = 0; ok = 1'b0; res = '0; seen = '0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (mem_ready) begin
                res = mem_result; ok = 1'b1;
                break;
            end
            stalls++;
            seen = sram_addr;
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        MEMread = 1'b0;
    endtask

    task automatic do_store(input logic [31:0] a, input logic [31:0] d, input logic rd,
                            output int stalls, output int we_low, output logic [1:0] be,
                            output logic [16:0] seen, output logic [63:0] wd, output logic ok);
        address = a; data = d; MEMwrite = 1'b1; MEMread = rd;
        stalls = 0; we_low = 0; ok = 1'b0; be = 2'b11; seen = '0; wd = '0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (!sram_we_n) begin
                we_low++; be = sram_be_n; seen = sram_addr; wd = sram_wdata;
            end
            if (mem_ready) begin
                ok = 1'b1;
                break;
            end
            stalls++;
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        MEMwrite = 1'b0; MEMread = 1'b0;
    endtask

    task automatic test_reset();
        @(posedge clk); @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        checks++; if (mem_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b want 1", mem_ready); end
        checks++; if (sram_we_n !== 1'b1) begin errors++; $display("FAIL reset_we_n got %b want 1", sram_we_n); end
        checks++; if (sram_be_n !== 2'b11) begin errors++; $display("FAIL reset_be_n got %b want 11", sram_be_n); end
        checks++; if (sram_addr !== 17'h0) begin errors++; $display("FAIL reset_addr got %h want 0", sram_addr); end
        checks++; if (hit_count !== 32'd0 || miss_count !== 32'd0) begin
            errors++; $display("FAIL reset_counters got %0d/%0d want 0/0", hit_count, miss_count); end
        @(posedge clk); #1;
    endtask

    task automatic test_miss_hit();
        int st; logic [31:0] res; logic [16:0] sa; logic ok;
        do_reset();
        do_load(32'd1028, 64'hBBBBBBBB_AAAAAAAA, st, res, sa, ok);
        checks++; if (!ok || st != 6) begin errors++; $display("FAIL miss_stalls got %0d ok=%b want 6", st, ok); end
        checks++; if (res !== 32'hBBBBBBBB) begin errors++; $display("FAIL miss_result got %h want bbbbbbbb", res); end
        checks++; if (sa !== 17'h0) begin errors++; $display("FAIL miss_addr got %h want 0", sa); end
        checks++; if (miss_count !== 32'd1) begin errors++; $display("FAIL miss_count got %0d want 1", miss_count); end
        do_load(32'd1024, 64'h0, st, res, sa, ok);
        checks++; if (!ok || st != 0) begin errors++; $display("FAIL hit_stalls got %0d want 0", st); end
        checks++; if (res !== 32'hAAAAAAAA) begin errors++; $display("FAIL hit_result got %h want aaaaaaaa", res); end
        checks++; if (hit_count !== 32'd1) begin errors++; $display("FAIL hit_count got %0d want 1", hit_count); end
    endtask

    task automatic test_lru();
        int st; logic [31:0] res; logic [16:0] sa; logic ok;
        do_reset();
        do_load(32'd1024, 64'h11111111_10101010, st, res, sa, ok);
        do_load(32'd1536, 64'h22222222_20202020, st, res, sa, ok);
        checks++; if (st != 6) begin errors++; $display("FAIL lru_fill2 got %0d want 6", st); end
        do_load(32'd1024, 64'h0, st, res, sa, ok);
        checks++; if (st != 0 || res !== 32'h10101010) begin
            errors++; $display("FAIL lru_hit1 got %0d/%h want 0/10101010", st, res); end
        do_load(32'd2048, 64'h33333333_30303030, st, res, sa, ok);
        checks++; if (st != 6 || res !== 32'h30303030) begin
            errors++; $display("FAIL lru_evict got %0d/%h want 6/30303030", st, res); end
        do_load(32'd1024, 64'h0, st, res, sa, ok);
        checks++; if (st != 0 || res !== 32'h10101010) begin
            errors++; $display("FAIL lru_keep got %0d/%h want 0/10101010", st, res); end
        do_load(32'd1536, 64'h44444444_40404040, st, res, sa, ok);
        checks++; if (st != 6) begin errors++; $display("FAIL lru_victim got %0d want 6", st); end
        checks++; if (hit_count !== 32'd2 || miss_count !== 32'd4) begin
            errors++; $display("FAIL lru_counts got %0d/%0d want 2/4", hit_count, miss_count); end
    endtask

    task automatic test_store();
        int st, wl, sb; logic [31:0] res, res_b; logic [16:0] sa; logic [1:0] be; logic [63:0] wd; logic ok;
        do_reset();
        do_load(32'd1028, 64'hBBBBBBBB_AAAAAAAA, st, res, sa, ok);
        do_store(32'd1028, 32'h12345678, 1'b0, st, wl, be, sa, wd, ok);
        checks++; if (!ok || st != 6 || wl != 5) begin
            errors++; $display("FAIL store_timing got stall=%0d we_low=%0d want 6/5", st, wl); end
        checks++; if (be !== 2'b01 || sa !== 17'h0) begin
            errors++; $display("FAIL store_be_addr got %b/%h want 01/0", be, sa); end
        checks++; if (wd !== 64'h12345678_12345678) begin
            errors++; $display("FAIL store_wdata got %h want 1234567812345678", wd); end
        checks++; if (miss_count !== 32'd1) begin errors++; $display("FAIL store_uncounted got %0d want 1", miss_count); end
        sram_rdata = 64'h55555555_66666666; address = 32'd1028; MEMread = 1'b1;
        sb = 0; res_b = '0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (i == 0) begin
                checks++; if (mem_ready !== 1'b1 || mem_result !== 32'h12345678) begin
                    errors++; $display("FAIL store_update got %b/%h want 1/12345678", mem_ready, mem_result); end
            end
            if (mem_ready_b) begin res_b = mem_result_b; break; end
            sb++;
            @(posedge clk); #1;
        end
        checks++; if (sb != 6 || res_b !== 32'h55555555) begin
            errors++; $display("FAIL store_invalidate got %0d/%h want 6/55555555", sb, res_b); end
        @(posedge clk); #1;
        MEMread = 1'b0;
    endtask

    task automatic test_both();
        int st, wl; logic [31:0] res; logic [16:0] sa; logic [1:0] be; logic [63:0] wd; logic ok;
        do_reset();
        do_store(32'd1024, 32'hCAFEF00D, 1'b1, st, wl, be, sa, wd, ok);
        checks++; if (wl != 5 || be !== 2'b10) begin
            errors++; $display("FAIL both_store got we_low=%0d be=%b want 5/10", wl, be); end
        checks++; if (miss_count !== 32'd0) begin errors++; $display("FAIL both_nocount got %0d want 0", miss_count); end
        do_load(32'd1024, 64'h0, st, res, sa, ok);
        checks++; if (st != 6) begin errors++; $display("FAIL both_nofill got %0d want 6", st); end
    endtask

    task automatic test_reset_abort();
        int st; logic [31:0] res; logic [16:0] sa; logic ok;
        do_reset();
        do_load(32'd1536, 64'h1, st, res, sa, ok);
        do_load(32'd1536, 64'h0, st, res, sa, ok);
        address = 32'd1024; MEMread = 1'b1; sram_rdata = 64'h77777777_88888888;
        @(posedge clk); @(posedge clk); @(posedge clk); #1;
        reset = 1'b1; MEMread = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        checks++; if (sram_we_n !== 1'b1 || mem_ready !== 1'b1) begin
            errors++; $display("FAIL abort_idle got we_n=%b ready=%b want 1/1", sram_we_n, mem_ready); end
        checks++; if (hit_count !== 32'd0 || miss_count !== 32'd0) begin
            errors++; $display("FAIL abort_counters got %0d/%0d want 0/0", hit_count, miss_count); end
        @(posedge clk); #1;
        do_load(32'd1024, 64'h77777777_88888888, st, res, sa, ok);
        checks++; if (st != 6 || res !== 32'h88888888) begin
            errors++; $display("FAIL abort_remiss got %0d/%h want 6/88888888", st, res); end
    endtask

    task automatic test_below_base();
        int st; logic [31:0] res; logic [16:0] sa; logic ok;
        do_reset();
        do_load(32'd1020, 64'hDDDDDDDD_CCCCCCCC, st, res, sa, ok);
        checks++; if (!ok || st != 6 || sa !== 17'h1FFFF) begin
            errors++; $display("FAIL below_miss got %0d/%h want 6/1ffff", st, sa); end
        checks++; if (res !== 32'hDDDDDDDD) begin errors++; $display("FAIL below_result got %h want dddddddd", res); end
        do_load(32'd1020, 64'h0, st, res, sa, ok);
        checks++; if (st != 0 || res !== 32'hDDDDDDDD) begin
            errors++; $display("FAIL below_hit got %0d/%h want 0/dddddddd", st, res); end
    endtask

    initial begin
        test_reset();
        test_miss_hit();
        test_lru();
        test_store();
        test_both();
        test_reset_abort();
        test_below_base();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
